ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter: the sending end of the keyboard/mouse link whose device-to-host direction the system already decodes. It takes one byte from the chipset (LED updates 0xED, reset 0xFF, typematic 0xF3, and similar), performs the request-to-send sequence on the open-collector `clkps2`/`dataps2` lines, and shifts out data, odd parity and stop. It then checks the device ACK and reports done or error. It sits beside the existing PS/2 receiver in the chipset clock domain; its `busy` output tells the receiver to ignore the bus while it owns the line.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: frequency of `clk_chipset`.
- `INHIBIT_US`, 100: time the host holds clock low before requesting to send.
- `TIMEOUT_US`, 15000: maximum time from clock release to the end of ACK.
- `clk_chipset` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `tx_data` in 8: byte to send, sampled on accept.
- `tx_valid` in 1: send request.
- `tx_ready` out 1: idle; a byte is accepted when `tx_valid && tx_ready`.
- `busy` out 1: the transmitter owns the bus; the receiver must discard edges.
- `tx_done` out 1: one-cycle pulse when the device ACK is received.
- `tx_err` out 1: one-cycle pulse on timeout or missing ACK.
- `ps2_clk_in` in 1: raw pin value, asynchronous.
- `ps2_data_in` in 1: raw pin value, asynchronous.
- `ps2_clk_oe` out 1: 1 drives `clkps2` low; 0 releases it (Z).
- `ps2_data_oe` out 1: 1 drives `dataps2` low; 0 releases it.

## Operation
- Inputs pass through a 2-FF synchronizer. A falling edge is detected when the previous synchronized value is 1 and the current value is 0.
- Tick constants: `INH_CYC = CLK_FREQ_HZ/1e6*INHIBIT_US`, `SETUP_CYC = CLK_FREQ_HZ/1e6` (1 µs), `TO_CYC = CLK_FREQ_HZ/1e6*TIMEOUT_US`. A single down-counter sized for `TO_CYC` serves all three.
- On accept: latch `tx_data` and compute parity `p = ~^tx_data` (odd parity).
- Shift frame, LSB first: {stop=1, p, d7..d0}.
- FSM states:
  - IDLE: `tx_ready=1`, both OE=0. On accept, go to INHIBIT.
  - INHIBIT: `clk_oe=1` for `INH_CYC` cycles, then go to RTS.
  - RTS: `clk_oe=1` and `data_oe=1` for `SETUP_CYC` cycles; this is the start bit. Then release clock, load the timeout counter and go to SHIFT with `bitcnt=0`.
  - SHIFT: on each falling clock edge, `data_oe <= ~frame[bitcnt]` and `bitcnt++`. After the edge with `bitcnt=9` (stop, data released), go to ACK.
  - ACK: on the next falling edge, sample data. If 0, go to WAIT_IDLE; if 1, pulse `tx_err` and go to IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1, then pulse `tx_done` and go to IDLE.
- Timeout: in SHIFT, ACK or WAIT_IDLE, counter reaching 0 → both OE=0, `tx_err` pulse, go to IDLE.
- `busy=1` in every state except IDLE.
- A `tx_valid` held high after done re-arms immediately: a new accept happens in the IDLE cycle.
- The device holding clock low at request time is not checked; the inhibit overrides it per protocol.

## Timing
- Reset values: state IDLE, `tx_ready=1`, `busy=0`, `tx_done=0`, `tx_err=0`, both OE=0, `bitcnt=0`. Reset mid-frame releases both lines on the next edge and emits no pulse.
- Accept → `clk_oe=1` on the following cycle.
- Clock is released exactly `INH_CYC+SETUP_CYC` cycles after accept.
- A device falling edge at the pin → `data_oe` update 3 cycles later (2 sync + 1 register), well inside the device's ~40 µs clock-low time.
- `tx_done` and `tx_err` are mutually exclusive, one pulse per accepted byte. The cycle carrying `tx_done` or `tx_err` is also the first IDLE cycle (`tx_ready=1`).

## Structure
- The shared chipset package holds the state enum (`PS2TX_IDLE`…`PS2TX_WAIT_IDLE`) and the µs-to-cycle conversion function, which is reused by the receiver's watchdog.
- One natural sub-module: `ps2_line_sync` (2-FF sync plus falling-edge detect). The receiver instantiates the same module.
- At the top level, pins are driven as `clkps2 = ps2_clk_oe ? 1'b0 : 1'bz`, and likewise for data.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and ACKing: expect clock low for 5000 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, stop 1 sampled on device rising edges, then a `tx_done` pulse with `tx_err=0`.
- Send 0x01: expect parity 0. Send 0xFF: expect parity 1. Send 0x00: expect parity 1.
- Device model does not ACK (data stays 1 on the 11th falling edge): expect a `tx_err` pulse, no `tx_done`, and `tx_ready=1` in the same cycle.
- Device never clocks after RTS: expect `tx_err` exactly `TO_CYC` cycles after clock release, with both OE=0.
- Assert `reset` during SHIFT at bit 4: expect both OE=0 and `tx_ready=1` on the next cycle, and no pulses.
- Hold `tx_valid` high with 0xF3 then 0x20: expect two back-to-back frames, two `tx_done` pulses, and `busy` low for exactly one cycle between them.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared chipset PS/2 definitions: host-transmit FSM states and the
// microsecond-to-clock-cycle conversion used by the transmitter and the receiver watchdog.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    PS2TX_IDLE,
    PS2TX_INHIBIT,
    PS2TX_RTS,
    PS2TX_SHIFT,
    PS2TX_ACK,
    PS2TX_WAIT_IDLE
  } ps2tx_state_e;

  // Data, parity and stop bits shifted after the start bit.
  localparam int unsigned FrameBits = 10;

  function automatic int unsigned us_to_cyc(input int unsigned freq_hz, input int unsigned us);
    return (freq_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for a raw PS/2 pin plus falling-edge detect on the synchronized value.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic sync,
  output logic fall
);

  // [0] metastability stage, [1] synchronized value, [2] previous synchronized value.
  logic [2:0] sh_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= 3'b111;
    end else begin
      sh_q <= {sh_q[1:0], raw};
    end
  end

  assign sync = sh_q[1];
  assign fall = sh_q[2] & ~sh_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out data/parity/stop on
// device clock falling edges, then check the device ACK and report done or error.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_US  = 15000
) (
  input  logic       clk_chipset,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned InhCyc   = us_to_cyc(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned SetupCyc = us_to_cyc(CLK_FREQ_HZ, 1);
  localparam int unsigned ToCyc    = us_to_cyc(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int unsigned MaxCyc   = (ToCyc > InhCyc) ? ToCyc : InhCyc;
  localparam int unsigned CntW     = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] InhLoad   = CntW'(InhCyc - 1);
  localparam logic [CntW-1:0] SetupLoad = CntW'(SetupCyc - 1);
  localparam logic [CntW-1:0] ToLoad    = CntW'(ToCyc - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [3:0]      LastBit   = 4'(FrameBits - 1);

  ps2tx_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [9:0]      frame_q, frame_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic            data_q, data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic clk_sync, clk_fall;
  logic data_sync, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk  (clk_chipset),
    .reset(reset),
    .raw  (ps2_clk_in),
    .sync (clk_sync),
    .fall (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk  (clk_chipset),
    .reset(reset),
    .raw  (ps2_data_in),
    .sync (data_sync),
    .fall (data_fall_unused)
  );

  always_ff @(posedge clk_chipset) begin
    if (reset) begin
      state_q  <= PS2TX_IDLE;
      cnt_q    <= '0;
      frame_q  <= '0;
      bitcnt_q <= '0;
      data_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      bitcnt_q <= bitcnt_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    bitcnt_d = bitcnt_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      PS2TX_IDLE: begin
        data_d   = 1'b0;
        bitcnt_d = '0;
        if (tx_valid) begin
          state_d = PS2TX_INHIBIT;
          frame_d = {1'b1, ~^tx_data, tx_data};
          cnt_d   = InhLoad;
        end
      end
      PS2TX_INHIBIT: begin
        if (cnt_q == '0) begin
          state_d = PS2TX_RTS;
          cnt_d   = SetupLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      PS2TX_RTS: begin
        if (cnt_q == '0) begin
          // Start bit stays driven low until the device's first falling edge.
          state_d  = PS2TX_SHIFT;
          cnt_d    = ToLoad;
          bitcnt_d = '0;
          data_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      PS2TX_SHIFT: begin
        cnt_d = cnt_q - CntOne;
        if (clk_fall) begin
          data_d   = ~frame_q[bitcnt_q];
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == LastBit) begin
            state_d = PS2TX_ACK;
          end
        end
      end
      PS2TX_ACK: begin
        cnt_d = cnt_q - CntOne;
        if (clk_fall) begin
          if (!data_sync) begin
            state_d = PS2TX_WAIT_IDLE;
          end else begin
            state_d = PS2TX_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      PS2TX_WAIT_IDLE: begin
        cnt_d = cnt_q - CntOne;
        if (clk_sync && data_sync) begin
          state_d = PS2TX_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = PS2TX_IDLE;
        data_d  = 1'b0;
      end
    endcase

    // Timeout wins over any same-cycle completion so done and err never coincide.
    if ((state_q inside {PS2TX_SHIFT, PS2TX_ACK, PS2TX_WAIT_IDLE}) && (cnt_q == '0)) begin
      state_d = PS2TX_IDLE;
      data_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    tx_ready    = 1'b0;
    busy        = 1'b1;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    unique case (state_q)
      PS2TX_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
      end
      PS2TX_INHIBIT: ps2_clk_oe = 1'b1;
      PS2TX_RTS: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      PS2TX_SHIFT, PS2TX_ACK, PS2TX_WAIT_IDLE: ps2_data_oe = data_q;
      default: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
      end
    endcase
  end

  assign tx_done = done_q;
  assign tx_err  = err_q;

endmodule
